// File: rtl/jtag_master_seq.sv
// Command-driven JTAG master: turns RESET / IR-scan / DR-scan / IDLE commands into TCK/TMS/TDI and captures TDO.
// Latency: 2*DIV clocks per TCK period; the response is valid the clock after the last period (next clock for len=0).
// Backpressure: cmd_ready only in idle with no pending response; rsp_valid/rsp_data held until rsp_ready.
//
// Ports: inst_clk/inst_rst (sync, active high); cmd_* valid/ready command channel (type, len, data);
//        rsp_* valid/ready response channel (captured TDO); busy_inst; jtag_tck/tms/tdi_inst to the TAP; inst_tdo from it.
// Optional: define JTAG_TRST_EN to add jtag_trst_n_inst, low during reset and the five tms=1 reset periods.
module jtag_master_seq #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 6,
    parameter int DIV   = 2
) (
    input  logic             inst_clk,
    input  logic             inst_rst,
    input  logic             inst_cmd_valid,
    output logic             cmd_ready_inst,
    input  logic [1:0]       inst_cmd_type,
    input  logic [LEN_W-1:0] inst_cmd_len,
    input  logic [WIDTH-1:0] inst_cmd_data,
    output logic             rsp_valid_inst,
    input  logic             inst_rsp_ready,
    output logic [WIDTH-1:0] rsp_data_inst,
    output logic             busy_inst,
    output logic             jtag_tck_inst,
    output logic             jtag_tms_inst,
    output logic             jtag_tdi_inst,
`ifdef JTAG_TRST_EN
    output logic             jtag_trst_n_inst,
`endif
    input  logic             inst_tdo
);

    localparam int CNT_W = $clog2(2 * DIV) + 1;
    localparam logic [CNT_W-1:0] PH_PRE  = CNT_W'(DIV - 1);     // last tck-low clock: TDO sampled as tck rises
    localparam logic [CNT_W-1:0] PH_RISE = CNT_W'(DIV);         // first tck-high clock
    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(2 * DIV - 1); // last clock of a TCK period
    localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(5);          // periods 0..4 tms=1, period 5 tms=0

    localparam logic [1:0] C_RESET = 2'b00;
    localparam logic [1:0] C_IR    = 2'b01;
    localparam logic [1:0] C_IDLE  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_SCAN, S_RUNI, S_RESP} state_e;

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
        T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_e;

    // Standard IEEE 1149.1 TAP state transition on one TCK rising edge.
    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            T_TLR:   return tms ? T_TLR   : T_RTI;
            T_RTI:   return tms ? T_SELDR : T_RTI;
            T_SELDR: return tms ? T_SELIR : T_CAPDR;
            T_CAPDR: return tms ? T_EX1DR : T_SHDR;
            T_SHDR:  return tms ? T_EX1DR : T_SHDR;
            T_EX1DR: return tms ? T_UPDR  : T_PADR;
            T_PADR:  return tms ? T_EX2DR : T_PADR;
            T_EX2DR: return tms ? T_UPDR  : T_SHDR;
            T_UPDR:  return tms ? T_SELDR : T_RTI;
            T_SELIR: return tms ? T_TLR   : T_CAPIR;
            T_CAPIR: return tms ? T_EX1IR : T_SHIR;
            T_SHIR:  return tms ? T_EX1IR : T_SHIR;
            T_EX1IR: return tms ? T_UPIR  : T_PAIR;
            T_PAIR:  return tms ? T_EX2IR : T_PAIR;
            T_EX2IR: return tms ? T_UPIR  : T_SHIR;
            T_UPIR:  return tms ? T_SELDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    function automatic logic is_shift(input tap_e s);
        return (s == T_SHDR) || (s == T_SHIR);
    endfunction

    // TMS for the scan period the TAP is about to spend in state s; the scan
    // path is steered purely from the tracked TAP state.
    function automatic logic scan_tms(input tap_e s, input logic ir, input logic last);
        case (s)
            T_RTI:           return 1'b1;
            T_SELDR:         return ir;
            T_SHDR, T_SHIR:  return last;
            T_EX1DR, T_EX1IR: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    state_e           state_q, state_d;
    tap_e             tap_q, tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] pcnt_q, pcnt_d;
    logic             known_q, known_d;
    logic [1:0]       type_q, type_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_q, rsp_d;
    logic             tck_q, tck_d;
    logic             tms_q, tms_d;
    logic             tdi_q, tdi_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             running_q, running_d, period_end;
`ifdef JTAG_TRST_EN
    logic             trst_q, trst_d;
`endif

    // State register
    always_ff @(posedge inst_clk) begin
        if (inst_rst) begin
            state_q <= S_IDLE;
            tap_q   <= T_TLR;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            known_q <= 1'b0;
            type_q  <= C_RESET;
            len_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef JTAG_TRST_EN
            trst_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            known_q <= known_d;
            type_q  <= type_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef JTAG_TRST_EN
            trst_q  <= trst_d;
`endif
        end
    end

    assign running_q  = (state_q == S_RST) || (state_q == S_SCAN) || (state_q == S_RUNI);
    assign period_end = running_q && (cnt_q == PH_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        known_d = known_q;
        type_d  = type_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;

        if (running_q) begin
            cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
            // tms_q is the value held for the whole period that is ending
            if (period_end) tap_d = tap_next(tap_q, tms_q);
        end

        case (state_q)
            S_IDLE: begin
                if (inst_cmd_valid && ready_q) begin
                    type_d = inst_cmd_type;
                    data_d = inst_cmd_data;
                    rsp_d  = '0;
                    cnt_d  = '0;
                    pcnt_d = '0;
                    // IDLE counts TCKs and is not bounded by the data width
                    if (inst_cmd_type != C_IDLE && inst_cmd_len > LEN_W'(WIDTH))
                        len_d = LEN_W'(WIDTH);
                    else
                        len_d = inst_cmd_len;
                    // A zero-length scan/idle generates no TCK at all, so it
                    // also skips the auto-reset and answers at once.
                    if (inst_cmd_type == C_RESET)     state_d = S_RST;
                    else if (inst_cmd_len == '0)      state_d = S_RESP;
                    else if (!known_q)                state_d = S_RST;
                    else if (inst_cmd_type == C_IDLE) state_d = S_RUNI;
                    else                              state_d = S_SCAN;
                end
            end
            S_RST: begin
                if (period_end) begin
                    if (pcnt_q == RST_LAST) begin
                        known_d = 1'b1;
                        pcnt_d  = '0;
                        if (type_q == C_RESET)     state_d = S_RESP;
                        else if (type_q == C_IDLE) state_d = S_RUNI;
                        else                       state_d = S_SCAN;
                    end else begin
                        pcnt_d = pcnt_q + LEN_W'(1);
                    end
                end
            end
            S_SCAN: begin
                if (cnt_q == PH_PRE && is_shift(tap_q))
                    rsp_d = rsp_q | (WIDTH'(inst_tdo) << pcnt_q);
                if (period_end) begin
                    if (is_shift(tap_q)) pcnt_d = pcnt_q + LEN_W'(1);
                    // Update -> RTI is the final period of a scan
                    if (tap_q == T_UPDR || tap_q == T_UPIR) state_d = S_RESP;
                end
            end
            S_RUNI: begin
                if (period_end) begin
                    if (pcnt_q == len_q - LEN_W'(1)) state_d = S_RESP;
                    else                             pcnt_d  = pcnt_q + LEN_W'(1);
                end
            end
            S_RESP: begin
                if (inst_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: registered pin values derived from the next state so
    // tms/tdi change on the first clock of each period together with tck=0.
    always_comb begin
        running_d = (state_d == S_RST) || (state_d == S_SCAN) || (state_d == S_RUNI);
        tck_d     = running_d && (cnt_d >= PH_RISE);
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        if (!running_d) begin
            tdi_d = 1'b0;
        end else if (cnt_d == '0) begin
            tdi_d = 1'b0;
            case (state_d)
                S_RST:  tms_d = (pcnt_d != RST_LAST);
                S_RUNI: tms_d = 1'b0;
                S_SCAN: begin
                    tms_d = scan_tms(tap_d, type_d == C_IR, pcnt_d == len_d - LEN_W'(1));
                    if (is_shift(tap_d)) tdi_d = |(data_d & (WIDTH'(1) << pcnt_d));
                end
                default: tms_d = tms_q;
            endcase
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
`ifdef JTAG_TRST_EN
        trst_d  = !((state_d == S_RST) && (pcnt_d < RST_LAST));
`endif
    end

    assign cmd_ready_inst = ready_q;
    assign rsp_valid_inst = (state_q == S_RESP);
    assign rsp_data_inst  = rsp_q;
    assign busy_inst      = busy_q;
    assign jtag_tck_inst  = tck_q;
    assign jtag_tms_inst  = tms_q;
    assign jtag_tdi_inst  = tdi_q;
`ifdef JTAG_TRST_EN
    assign jtag_trst_n_inst = trst_q;
`endif

endmodule

// File: tb/tb_jtag_master_seq.sv
// Bench for jtag_master_seq: directed plus randomized commands against a sequence-level model.
// Latency: checks exact accept-to-response cycle counts and TCK high/low widths.
// Backpressure: holds rsp_ready low for a while and checks the response is held and no command is accepted.
module tb_jtag_master_seq;
    localparam int WIDTH = 32;
    localparam int LEN_W = 6;
    localparam int DIV   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_type;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             tck, tms, tdi;
    logic             tdo = 1'b0;
`ifdef JTAG_TRST_EN
    logic             trst_n;
`endif

    always #5 clk = ~clk;

    jtag_master_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DIV(DIV)) dut (
        .inst_clk(clk), .inst_rst(rst),
        .inst_cmd_valid(cmd_valid), .cmd_ready_inst(cmd_ready),
        .inst_cmd_type(cmd_type), .inst_cmd_len(cmd_len), .inst_cmd_data(cmd_data),
        .rsp_valid_inst(rsp_valid), .inst_rsp_ready(rsp_ready), .rsp_data_inst(rsp_data),
        .busy_inst(busy), .jtag_tck_inst(tck), .jtag_tms_inst(tms), .jtag_tdi_inst(tdi),
`ifdef JTAG_TRST_EN
        .jtag_trst_n_inst(trst_n),
`endif
        .inst_tdo(tdo)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pin monitor: records tms/tdi (and trst) at every tck rise, checks
    // tck widths, and plays the TAP's TDO for the shift periods.
    bit          mon_tms[$];
    bit          mon_tdi[$];
    bit          mon_trst[$];
    logic        prev_tck = 1'b0;
    int          hi_run = 0;
    int          lo_run = 0;
    int          sh_start = -1;
    int          sh_len = 0;
    logic [31:0] tdo_word = '0;

    function automatic logic tdo_for(input int n);
        if (sh_start >= 0 && n >= sh_start && n < sh_start + sh_len) return tdo_word[n - sh_start];
        return 1'($urandom);
    endfunction

    always @(negedge clk) begin
        if (tck) begin
            if (!prev_tck) begin
                if (mon_tms.size() > 0 && !rst) chk("tck_low_width", lo_run, DIV);
                mon_tms.push_back(tms);
                mon_tdi.push_back(tdi);
`ifdef JTAG_TRST_EN
                mon_trst.push_back(trst_n);
`endif
                hi_run = 1;
            end else begin
                hi_run++;
            end
            lo_run = 0;
        end else begin
            if (prev_tck && !rst) chk("tck_high_width", hi_run, DIV);
            lo_run++;
            tdo = tdo_for(mon_tms.size());
        end
        prev_tck = tck;
    end

    // Sequence-level reference model state
    bit known = 1'b0;
    bit exp_tms[$];

    task automatic run_cmd(input logic [1:0] typ, input logic [LEN_W-1:0] len,
                           input logic [31:0] data, input logic [31:0] word, input int hold);
        int          len_eff;
        int          ss;
        int          cyc;
        int          bad;
        logic        last_tck;
        logic [63:0] m;
        logic [31:0] exp_rsp;
        bit          need_rst;
        len_eff = (typ != 2'b11 && int'(len) > WIDTH) ? WIDTH : int'(len);
        ss = -1;
        exp_tms.delete();
        need_rst = (typ == 2'b00) || (!known && len_eff > 0);
        if (need_rst) begin
            for (int i = 0; i < 5; i++) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end
        if (typ == 2'b11) begin
            for (int i = 0; i < len_eff; i++) exp_tms.push_back(1'b0);
        end else if (typ != 2'b00 && len_eff > 0) begin
            exp_tms.push_back(1'b1);
            if (typ == 2'b01) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b0);
            ss = exp_tms.size();
            for (int k = 0; k < len_eff; k++) exp_tms.push_back(k == len_eff - 1);
            exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end
        m = (len_eff >= 32) ? 64'hFFFF_FFFF : ((64'd1 << len_eff) - 64'd1);
        exp_rsp = (typ == 2'b01 || typ == 2'b10) ? (word & m[31:0]) : 32'h0;

        @(negedge clk);
        sh_start = ss;
        sh_len   = (ss >= 0) ? len_eff : 0;
        tdo_word = word;
        mon_tms.delete();
        mon_tdi.delete();
        mon_trst.delete();
        cmd_type  = typ;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("cmd_ready_seen", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        last_tck = 1'b0;
        while (!rsp_valid && cyc < 2000) begin
            last_tck = tck;
            @(negedge clk);
            cyc++;
        end
        chk("rsp_latency", cyc, 2 * DIV * exp_tms.size() + 1);
        if (exp_tms.size() > 0) chk("tck_high_before_rsp", last_tck, 1'b1);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("tck_count", mon_tms.size(), exp_tms.size());
        bad = -1;
        for (int i = 0; i < exp_tms.size() && i < mon_tms.size(); i++)
            if (bad < 0 && mon_tms[i] != exp_tms[i]) bad = i;
        chk("tms_seq_first_bad", bad, -1);
        if (ss >= 0) begin
            bad = -1;
            for (int k = 0; k < len_eff && ss + k < mon_tdi.size(); k++)
                if (bad < 0 && mon_tdi[ss + k] != data[k]) bad = k;
            chk("tdi_shift_first_bad", bad, -1);
        end
`ifdef JTAG_TRST_EN
        bad = -1;
        for (int i = 0; i < mon_trst.size(); i++)
            if (bad < 0 && mon_trst[i] != !(need_rst && i < 5)) bad = i;
        chk("trst_seq_first_bad", bad, -1);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_data", rsp_data, exp_rsp);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_tck", tck, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
        chk("post_tdi", tdi, 1'b0);
        if (exp_tms.size() > 0) begin
            chk("post_tms_hold", tms, 1'b0);
            known = 1'b1;
        end
    endtask

    initial begin
        int cyc;
        logic [1:0] rt;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_type = '0;
        cmd_len = '0;
        cmd_data = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 1'b0);
        chk("rst_tms", tms, 1'b1);
        chk("rst_tdi", tdi, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
`ifdef JTAG_TRST_EN
        chk("rst_trst_n", trst_n, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        // DR scan with auto-reset; TAP plays an IDCODE of 0x12345677
        run_cmd(2'b10, 6'd8, 32'hA5, 32'h1234_5677, 0);
        // explicit RESET then IR scan with capture pattern 01
        run_cmd(2'b00, 6'd0, 32'h0, 32'h0, 0);
        run_cmd(2'b01, 6'd4, 32'h2, 32'h1, 0);
        // IDLE clocks
        run_cmd(2'b11, 6'd3, 32'h0, 32'h0, 0);
        // zero-length scans and idle
        run_cmd(2'b10, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_cmd(2'b01, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_cmd(2'b11, 6'd0, 32'h0, 32'h0, 0);
        // clamped length
        run_cmd(2'b10, 6'd40, 32'hDEAD_BEEF, 32'hC001_D00D, 0);
        // response backpressure
        run_cmd(2'b10, 6'd5, 32'h15, 32'h0A, 10);

        // abort a DR scan in the middle of its shift
        @(negedge clk);
        mon_tms.delete();
        cmd_type = 2'b10;
        cmd_len = 6'd20;
        cmd_data = $urandom;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(mon_tms.size() >= 8 && tck) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_shift", mon_tms.size() >= 8 && tck, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tck", tck, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        known = 1'b0;
        @(negedge clk);
        run_cmd(2'b10, 6'd12, 32'h0000_0ABC, 32'h0000_0F0F, 0);

        // randomized commands
        for (int n = 0; n < 12; n++) begin
            rt = 2'($urandom_range(0, 3));
            run_cmd(rt, (rt == 2'b11) ? LEN_W'($urandom_range(0, 10)) : LEN_W'($urandom_range(0, 40)),
                    $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtag_master_seq.md
Name: jtag_master_seq

Overview:
- Command-driven JTAG master that generates TCK/TMS/TDI for the on-chip TAP controller and captures its TDO.
- Sits directly upstream of the TAP controller: its outputs drive the TAP's tck/tms/tdi (and optionally trst_n) pins; its inst_tdo input is the TAP's tdo.
- A host/debug FSM issues RESET, IR-scan, DR-scan and IDLE commands and gets one response per command.

Parameters:
- WIDTH, 32, maximum scan length in bits; width of the cmd_data and rsp_data ports.
- LEN_W, 6, width of the cmd_len port; must satisfy 2^LEN_W > WIDTH.
- DIV, 2, TCK half-period in inst_clk cycles; DIV ≥ 1.

Ports:
- inst_clk  in  1  system clock; the only clock.
- inst_rst  in  1  synchronous, active-high reset.
- inst_cmd_valid  in  1  command valid.
- cmd_ready_inst  out  1  command accept.
- inst_cmd_type  in  2  00 RESET, 01 IR scan, 10 DR scan, 11 IDLE.
- inst_cmd_len  in  LEN_W  scan bit count, or TCK count for IDLE.
- inst_cmd_data  in  WIDTH  TDI bits, shifted out LSB first.
- rsp_valid_inst  out  1  response valid.
- inst_rsp_ready  in  1  response accept.
- rsp_data_inst  out  WIDTH  captured TDO bits.
- busy_inst  out  1  command in progress or response pending.
- jtag_tck_inst  out  1  to TAP tck.
- jtag_tms_inst  out  1  to TAP tms.
- jtag_tdi_inst  out  1  to TAP tdi.
- inst_tdo  in  1  from TAP tdo.

Behaviour:
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0 (rises the first clock after reset), rsp_valid=0, rsp_data=0, busy=0. The internal tap_known flag clears to 0.
- Command handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in the IDLE state with no pending response. type, len and data are registered on accept.
- TCK bit period is 2*DIV clocks:
  - jtag_tck low for the first DIV clocks, high for the next DIV.
  - tms/tdi update on the first clock of the period, while tck is low.
  - inst_tdo is sampled on the clock at which tck rises.
- Every TCK period moves the tracked TAP state per the standard 16-state TAP FSM.
- RESET: 5 periods with tms=1, then 1 period with tms=0; the TAP ends in Run-Test/Idle (RTI). Sets tap_known=1.
- Auto-reset: if tap_known=0, an IR, DR or IDLE command first performs the RESET sequence, then itself.
- DR scan from RTI, TMS sequence:
  - 1,0 (Select-DR, Capture-DR).
  - 0 (Shift-DR).
  - len shift periods with tms=0, except the last shift period has tms=1 (Exit1).
  - 1 (Update), then 0 (RTI).
- IR scan: identical, with the prefix 1,1,0 then 0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- Shift data:
  - TDI bit k = cmd_data[k] during shift period k.
  - The TDO sampled in shift period k goes to rsp_data[k].
  - rsp_data bits ≥ len read 0.
- IDLE: len periods with tms=0 (stays in RTI). len=0 generates no TCK.
- Scan with len=0: no TCK; the response is issued immediately with rsp_data=0. len>WIDTH is clamped to WIDTH.
- Response: every command produces exactly one response. rsp_data=0 for RESET and IDLE.
  - rsp_valid asserts the clock after the final period's last tck-high clock.
  - rsp_valid and rsp_data are held until rsp_ready; the handshake completes on rsp_valid && rsp_ready.
- Idle/between commands: tck=0; tms holds its last value; tdi=0.
- Mid-operation reset: inst_rst at any point aborts the command. tck goes 0 on the next clock, the pending response is discarded, and tap_known is cleared.
- Commands presented while cmd_ready=0 are held by the requester and not lost.

Optional Feature:
- Macro JTAG_TRST_EN.
- With JTAG_TRST_EN defined:
  - Adds output port jtag_trst_n_inst (1 bit).
  - The port is 0 during reset and during the 5 tms=1 periods of every RESET or auto-reset sequence; otherwise 1.
- Without JTAG_TRST_EN: the port is absent; reset of the TAP is by TMS only.

Test Plan:
- After reset, DR scan with len=8, data=0xA5: auto-RESET runs first (5×tms=1, 1×tms=0). DR TMS then reads 1,0,0,0×7,1,1,0. TDI sequence is 1,0,1,0,0,1,0,1. With a TAP-model IDCODE of 0x1234_5677, rsp_data=0x77.
- IR scan with len=4, data=0x2 after a RESET: TMS reads 1,1,0,0,0,0,0,1,1,0. TDI shift bits read 0,1,0,0. With the TAP IR capture of 01, rsp_data=0x1 and the TAP instruction=0x2.
- DIV=2, IDLE with len=3: exactly 3 tck pulses, each 2 clocks high and 2 clocks low, with tms=0. rsp_valid follows with rsp_data=0.
- Scan with len=0: no tck edge, and rsp_valid on the clock after accept. len=40 with WIDTH=32: exactly 32 shift periods.
- Hold inst_rsp_ready=0 for 10 clocks after a response: rsp_valid and rsp_data stay stable, and cmd_ready stays 0. A new command is accepted only after the response handshake.
- Assert inst_rst during the shift of a DR scan: jtag_tck=0 and rsp_valid=0 the next clock. The next DR scan re-runs auto-RESET. With JTAG_TRST_EN defined, jtag_trst_n is 0 during its first 5 periods.
